key_expand_seq: RTL

KEY_EXPAND_SEQ -- requirements
Module: key_expand_seq

---
 rtl/key_expand_seq.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/key_expand_seq.sv
`default_nettype none
// ============================================================================
// Module  : key_expand_seq
// Brief   : AES-128/192/256 key schedule; one word per cycle, one round key per four words
// Revision: 1.0
// ============================================================================

module key_expand_seq #(
   parameter int NK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [32*NK-1:0]  key_in,
   output logic              busy,
   output logic              rk_valid,
   output logic [3:0]        rk_index,
   output logic [127:0]      round_key,
   output logic              done
);

   localparam int         NR          = NK + 6;
   localparam int         C_LAST_WORD = 4*(NR+1) - 1;
   localparam logic [7:0] C_RCON_LAST = (NK == 4) ? 8'h36 : ((NK == 6) ? 8'h80 : 8'h40);

   localparam logic [2047:0] C_SBOX = {
      128'h637c777b_f26b6fc5_3001672b_fed7ab76,
      128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
      128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
      128'h04c723c3_1896059a_071280e2_eb27b275,
      128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
      128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
      128'hd0efaafb_434d3385_45f9027f_503c9fa8,
      128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
      128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
      128'h60814fdc_222a9088_46eeb814_de5e0bdb,
      128'he0323a0a_4906245c_c2d3ac62_9195e479,
      128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
      128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
      128'h703eb566_4803f60e_613557b9_86c11d9e,
      128'he1f89811_69d98e94_9b1e87e9_ce5528df,
      128'h8ca1890d_bfe64268_41992d0f_b054bb16
   };

   generate
      if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
         $error("key_expand_seq: NK must be 4, 6 or 8");
      end
   endgenerate

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [2:0]        pos_q, pos_d;
   logic [7:0]        rcon_q, rcon_d;
   logic [32*NK-1:0]  win_q, win_d;
   logic [127:0]      acc_q, acc_d;
   logic [127:0]      round_key_q, round_key_d;
   logic [3:0]        rk_index_q, rk_index_d;
   logic              rk_valid_q, rk_valid_d;
   logic              done_q, done_d;

   logic [31:0]       w_prev;
   logic [31:0]       w_oldest;
   logic [31:0]       w_key_word;
   logic [31:0]       w_rot;
   logic [31:0]       w_sub_in;
   logic [31:0]       w_sub_out;
   logic [31:0]       w_t;
   logic [31:0]       w_word;
   logic              w_in_key;
   logic              w_rcon_rule;
   logic              w_sub_rule;
   logic              w_last;

   function automatic logic [7:0] sbox(input logic [7:0] a);
      sbox = C_SBOX[{~a, 3'b000} +: 8];
   endfunction

   // Window: oldest word w[i-NK] at the MSB end, newest w[i-1] at the LSB end.
   assign w_prev      = win_q[31:0];
   assign w_oldest    = win_q[32*NK-1 -: 32];
   assign w_rot       = {w_prev[23:0], w_prev[31:24]};
   assign w_in_key    = (cnt_q < 6'(NK));
   assign w_rcon_rule = !w_in_key && (pos_q == 3'd0);
   assign w_sub_rule  = !w_in_key && (NK == 8) && (pos_q == 3'd4);
   assign w_sub_in    = w_rcon_rule ? w_rot : w_prev;
   assign w_last      = (cnt_q == 6'(C_LAST_WORD));

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_sbox
         assign w_sub_out[8*g +: 8] = sbox(w_sub_in[8*g +: 8]);
      end
   endgenerate

   always_comb begin
      w_key_word = '0;
      for (int j = 0; j < NK; j++) begin
         if (cnt_q[2:0] == 3'(j)) begin
            w_key_word = win_q[32*(NK-1-j) +: 32];
         end
      end
   end

   always_comb begin
      w_t = w_prev;
      if (w_rcon_rule) begin
         w_t = w_sub_out ^ {rcon_q, 24'h0};
      end else if (w_sub_rule) begin
         w_t = w_sub_out;
      end
      w_word = w_in_key ? w_key_word : (w_oldest ^ w_t);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pos_d       = pos_q;
      rcon_d      = rcon_q;
      win_d       = win_q;
      acc_d       = acc_q;
      round_key_d = round_key_q;
      rk_index_d  = rk_index_q;
      rk_valid_d  = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               win_d   = key_in;
               cnt_d   = 6'd0;
               pos_d   = 3'd0;
               rcon_d  = 8'h01;
               state_d = RUN;
            end
         end
         RUN: begin
            cnt_d = cnt_q + 6'd1;
            pos_d = (pos_q == 3'(NK-1)) ? 3'd0 : pos_q + 3'd1;
            if (!w_in_key) begin
               win_d = {win_q[32*NK-33:0], w_word};
            end
            // rcon stops at its final value so it never steps past the table end.
            if (w_rcon_rule && (rcon_q != C_RCON_LAST)) begin
               rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
            case (cnt_q[1:0])
               2'd0:    acc_d[127:96] = w_word;
               2'd1:    acc_d[95:64]  = w_word;
               2'd2:    acc_d[63:32]  = w_word;
               default: acc_d[31:0]   = w_word;
            endcase
            if (cnt_q[1:0] == 2'd3) begin
               round_key_d = acc_d;
               rk_index_d  = cnt_q[5:2];
               rk_valid_d  = 1'b1;
            end
            if (w_last) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 6'd0;
         pos_q       <= 3'd0;
         rcon_q      <= 8'h01;
         win_q       <= '0;
         acc_q       <= '0;
         round_key_q <= '0;
         rk_index_q  <= 4'd0;
         rk_valid_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pos_q       <= pos_d;
         rcon_q      <= rcon_d;
         win_q       <= win_d;
         acc_q       <= acc_d;
         round_key_q <= round_key_d;
         rk_index_q  <= rk_index_d;
         rk_valid_q  <= rk_valid_d;
         done_q      <= done_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign rk_valid  = rk_valid_q;
   assign rk_index  = rk_index_q;
   assign round_key = round_key_q;
   assign done      = done_q;

endmodule

`default_nettype wire
